// File: rtl/turn_controller_if.sv
// rtl/turn_controller_if.sv - player request and recorder commit bundle for turn_controller
interface turn_controller_if;
   logic        req_a;
   logic [3:0]  pos_a;
   logic        req_b;
   logic [3:0]  pos_b;
   logic [17:0] game_grid;
   logic        player_a_move;
   logic        player_b_move;
   logic [3:0]  pos;

   modport master (
      input  req_a, pos_a, req_b, pos_b, game_grid,
      output player_a_move, player_b_move, pos
   );

   modport slave (
      output req_a, pos_a, req_b, pos_b, game_grid,
      input  player_a_move, player_b_move, pos
   );
endinterface

// File: rtl/turn_controller.sv
// rtl/turn_controller.sv - tic-tac-toe turn sequencing, move commit, win and timeout detection
module turn_controller #(
   parameter logic [15:0] TIMEOUT_CYCLES = 16'd1000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   turn_controller_if.master bus,
   output logic              game_state,
   output logic              turn,
   output logic [1:0]        winner,
   output logic              illegal,
   output logic              timeout,
   output logic [7:0]        move_count
);

   typedef enum logic [2:0] {IDLE, TURN, ISSUE, SETTLE, CHECK, OVER} state_t;

   state_t      state;
   logic [15:0] timer;

   logic        act_req;
   logic [3:0]  act_pos;
   logic [8:0]  occupied;
   logic [8:0]  marks;
   logic        legal;
   logic        mover_wins;

   // Only the player whose turn it is gets looked at; the grid is indexed only for cells 0-8.
   always_comb begin
      act_req  = turn ? bus.req_b : bus.req_a;
      act_pos  = turn ? bus.pos_b : bus.pos_a;
      occupied = bus.game_grid[8:0] | bus.game_grid[17:9];
      marks    = turn ? bus.game_grid[17:9] : bus.game_grid[8:0];
      legal    = 1'b0;
      if (act_pos <= 4'd8)
         legal = ~occupied[act_pos];
      mover_wins = (marks[0] & marks[1] & marks[2]) |
                   (marks[3] & marks[4] & marks[5]) |
                   (marks[6] & marks[7] & marks[8]) |
                   (marks[0] & marks[3] & marks[6]) |
                   (marks[1] & marks[4] & marks[7]) |
                   (marks[2] & marks[5] & marks[8]) |
                   (marks[0] & marks[4] & marks[8]) |
                   (marks[2] & marks[4] & marks[6]);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state             <= IDLE;
         timer             <= 16'd0;
         game_state        <= 1'b0;
         bus.player_a_move <= 1'b0;
         bus.player_b_move <= 1'b0;
         bus.pos           <= 4'd0;
         turn              <= 1'b0;
         winner            <= 2'b00;
         illegal           <= 1'b0;
         timeout           <= 1'b0;
         move_count        <= 8'd0;
      end else begin
         bus.player_a_move <= 1'b0;
         bus.player_b_move <= 1'b0;
         illegal           <= 1'b0;
         timeout           <= 1'b0;
         case (state)
            IDLE, OVER: begin
               if (start) begin
                  state      <= TURN;
                  game_state <= 1'b1;
                  turn       <= 1'b0;
                  winner     <= 2'b00;
                  move_count <= 8'd0;
                  timer      <= 16'd0;
               end
            end
            TURN: begin
               // A legal move wins over an expiring timer in the same cycle.
               if (act_req && legal) begin
                  state   <= ISSUE;
                  bus.pos <= act_pos;
                  if (turn)
                     bus.player_b_move <= 1'b1;
                  else
                     bus.player_a_move <= 1'b1;
               end else begin
                  if (act_req)
                     illegal <= 1'b1;
                  if (timer == TIMEOUT_CYCLES - 16'd1) begin
                     timeout <= 1'b1;
                     turn    <= ~turn;
                     timer   <= 16'd0;
                  end else begin
                     timer <= timer + 16'd1;
                  end
               end
            end
            ISSUE:  state <= SETTLE;
            SETTLE: state <= CHECK;
            CHECK: begin
               if (move_count != 8'hFF)
                  move_count <= move_count + 8'd1;
               if (mover_wins) begin
                  state      <= OVER;
                  game_state <= 1'b0;
                  winner     <= turn ? 2'b10 : 2'b01;
               end else begin
                  state <= TURN;
                  turn  <= ~turn;
                  timer <= 16'd0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
